// File: rtl/alu_ctrl_decode_idex.sv
// RV32I ID-stage decoder feeding the ID/EX pipeline register.
// Produces one-hot ALU control, branch opcode, operand selects and writeback controls.
module alu_ctrl_decode_idex #(
    parameter int unsigned ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [31:0]          instr,
    input  logic [31:0]          pc,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [9:0]           alu_ctrl,
    output logic [2:0]           bropcode,
    output logic                 is_branch,
    output logic                 is_jump,
    output logic [1:0]           a_sel,
    output logic [1:0]           b_sel,
    output logic [31:0]          imm,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic                 reg_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          pc_q,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    localparam logic [9:0] AluAdd  = 10'h001;
    localparam logic [9:0] AluSub  = 10'h002;
    localparam logic [9:0] AluSll  = 10'h004;
    localparam logic [9:0] AluSlt  = 10'h008;
    localparam logic [9:0] AluSltu = 10'h010;
    localparam logic [9:0] AluXor  = 10'h020;
    localparam logic [9:0] AluSrl  = 10'h040;
    localparam logic [9:0] AluSra  = 10'h080;
    localparam logic [9:0] AluOr   = 10'h100;
    localparam logic [9:0] AluAnd  = 10'h200;

    localparam logic [2:0] BropNone = 3'b010;

    localparam logic [1:0] ASelRs1  = 2'd0;
    localparam logic [1:0] ASelPc   = 2'd1;
    localparam logic [1:0] ASelZero = 2'd2;
    localparam logic [1:0] BSelRs2  = 2'd0;
    localparam logic [1:0] BSelImm  = 2'd1;
    localparam logic [1:0] BSelFour = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [9:0]  alu_ctrl;
        logic [2:0]  bropcode;
        logic        is_branch;
        logic        is_jump;
        logic [1:0]  a_sel;
        logic [1:0]  b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] pc;
        logic        illegal;
    } idex_t;

    function automatic idex_t bubble_state();
        idex_t s;
        s          = '0;
        s.bropcode = BropNone;
        return s;
    endfunction

    // alt selects SUB / SRA on the funct3 codes that have an alternate form
    function automatic logic [9:0] alu_onehot(input logic [2:0] f3, input logic alt);
        logic [9:0] oh;
        case (f3)
            3'b000:  oh = alt ? AluSub : AluAdd;
            3'b001:  oh = AluSll;
            3'b010:  oh = AluSlt;
            3'b011:  oh = AluSltu;
            3'b100:  oh = AluXor;
            3'b101:  oh = alt ? AluSra : AluSrl;
            3'b110:  oh = AluOr;
            default: oh = AluAnd;
        endcase
        return oh;
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        f7_zero;
    logic        f7_alt;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic [9:0]  dec_alu;
    logic [2:0]  dec_brop;
    logic        dec_branch;
    logic        dec_jump;
    logic [1:0]  dec_a_sel;
    logic [1:0]  dec_b_sel;
    logic [31:0] dec_imm;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_illegal;

    always_comb begin
        dec_alu       = '0;
        dec_brop      = BropNone;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_a_sel     = ASelRs1;
        dec_b_sel     = BSelRs2;
        dec_imm       = '0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_illegal   = 1'b0;
        case (opcode)
            OpcOp: begin
                if ((funct3 == 3'b000 || funct3 == 3'b101) ? (f7_zero || f7_alt) : f7_zero) begin
                    dec_alu       = alu_onehot(funct3, f7_alt);
                    dec_reg_write = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OpcOpImm: begin
                if ((funct3 == 3'b001 && !f7_zero) ||
                    (funct3 == 3'b101 && !(f7_zero || f7_alt))) begin
                    dec_illegal = 1'b1;
                end else begin
                    // funct3 000 has no SUB form in OP-IMM; only shifts honour funct7
                    dec_alu       = alu_onehot(funct3, (funct3 == 3'b101) && f7_alt);
                    dec_b_sel     = BSelImm;
                    dec_reg_write = 1'b1;
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        dec_imm = {27'b0, instr[24:20]};
                    end else begin
                        dec_imm = imm_i;
                    end
                end
            end
            OpcBranch: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_alu    = AluSub;
                    dec_brop   = funct3;
                    dec_branch = 1'b1;
                    dec_imm    = imm_b;
                end
            end
            OpcLoad: begin
                dec_alu       = AluAdd;
                dec_b_sel     = BSelImm;
                dec_imm       = imm_i;
                dec_mem_read  = 1'b1;
                dec_reg_write = 1'b1;
            end
            OpcStore: begin
                dec_alu       = AluAdd;
                dec_b_sel     = BSelImm;
                dec_imm       = imm_s;
                dec_mem_write = 1'b1;
            end
            OpcLui: begin
                dec_alu       = AluAdd;
                dec_a_sel     = ASelZero;
                dec_b_sel     = BSelImm;
                dec_imm       = imm_u;
                dec_reg_write = 1'b1;
            end
            OpcAuipc: begin
                dec_alu       = AluAdd;
                dec_a_sel     = ASelPc;
                dec_b_sel     = BSelImm;
                dec_imm       = imm_u;
                dec_reg_write = 1'b1;
            end
            OpcJal: begin
                dec_alu       = AluAdd;
                dec_a_sel     = ASelPc;
                dec_b_sel     = BSelFour;
                dec_imm       = imm_j;
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
            end
            OpcJalr: begin
                if (funct3 != 3'b000) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_alu       = AluAdd;
                    dec_a_sel     = ASelPc;
                    dec_b_sel     = BSelFour;
                    dec_imm       = imm_i;
                    dec_jump      = 1'b1;
                    dec_reg_write = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    idex_t st_d;
    idex_t st_q;

    // Illegal instructions keep valid/pc but carry a bubble's controls
    always_comb begin
        st_d = bubble_state();
        if (in_valid) begin
            st_d.valid = 1'b1;
            st_d.pc    = pc;
            if (dec_illegal) begin
                st_d.illegal = 1'b1;
            end else begin
                st_d.alu_ctrl  = dec_alu;
                st_d.bropcode  = dec_brop;
                st_d.is_branch = dec_branch;
                st_d.is_jump   = dec_jump;
                st_d.a_sel     = dec_a_sel;
                st_d.b_sel     = dec_b_sel;
                st_d.imm       = dec_imm;
                st_d.rs1       = instr[19:15];
                st_d.rs2       = instr[24:20];
                st_d.rd        = dec_reg_write ? instr[11:7] : 5'd0;
                st_d.reg_write = dec_reg_write;
                st_d.mem_read  = dec_mem_read;
                st_d.mem_write = dec_mem_write;
            end
        end
    end

    logic [ILL_CNT_W-1:0] ill_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= bubble_state();
            ill_cnt_q <= '0;
        end else if (flush) begin
            st_q <= bubble_state();
        end else if (!stall) begin
            st_q <= st_d;
            if (in_valid && dec_illegal && ill_cnt_q != {ILL_CNT_W{1'b1}}) begin
                ill_cnt_q <= ill_cnt_q + ILL_CNT_W'(1);
            end
        end
    end

    assign out_valid = st_q.valid;
    assign alu_ctrl  = st_q.alu_ctrl;
    assign bropcode  = st_q.bropcode;
    assign is_branch = st_q.is_branch;
    assign is_jump   = st_q.is_jump;
    assign a_sel     = st_q.a_sel;
    assign b_sel     = st_q.b_sel;
    assign imm       = st_q.imm;
    assign rs1       = st_q.rs1;
    assign rs2       = st_q.rs2;
    assign rd        = st_q.rd;
    assign reg_write = st_q.reg_write;
    assign mem_read  = st_q.mem_read;
    assign mem_write = st_q.mem_write;
    assign pc_q      = st_q.pc;
    assign illegal   = st_q.illegal;
    assign ill_cnt   = ill_cnt_q;

endmodule

// File: tb/tb_alu_ctrl_decode_idex.sv
// Self-checking bench for alu_ctrl_decode_idex: directed cases plus randomized
// stimulus compared against an instruction-level reference model.
module tb_alu_ctrl_decode_idex;

    localparam int unsigned CntW   = 8;
    localparam int          CntMax = (1 << CntW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [31:0]     instr;
    logic [31:0]     pc;
    logic            stall;
    logic            flush;
    logic            out_valid;
    logic [9:0]      alu_ctrl;
    logic [2:0]      bropcode;
    logic            is_branch;
    logic            is_jump;
    logic [1:0]      a_sel;
    logic [1:0]      b_sel;
    logic [31:0]     imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [31:0]     pc_q;
    logic            illegal;
    logic [CntW-1:0] ill_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    alu_ctrl_decode_idex #(.ILL_CNT_W(CntW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .instr     (instr),
        .pc        (pc),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .alu_ctrl  (alu_ctrl),
        .bropcode  (bropcode),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .a_sel     (a_sel),
        .b_sel     (b_sel),
        .imm       (imm),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .pc_q      (pc_q),
        .illegal   (illegal),
        .ill_cnt   (ill_cnt)
    );

    typedef struct packed {
        logic        out_valid;
        logic [9:0]  alu_ctrl;
        logic [2:0]  bropcode;
        logic        is_branch;
        logic        is_jump;
        logic [1:0]  a_sel;
        logic [1:0]  b_sel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] pc_q;
        logic        illegal;
    } ex_t;

    function automatic ex_t bubble();
        ex_t e;
        e          = '0;
        e.bropcode = 3'b010;
        return e;
    endfunction

    function automatic ex_t observe();
        ex_t e;
        e = '{out_valid, alu_ctrl, bropcode, is_branch, is_jump, a_sel, b_sel, imm,
              rs1, rs2, rd, reg_write, mem_read, mem_write, pc_q, illegal};
        return e;
    endfunction

    // Operand fields are unconstrained for an illegal instruction
    function automatic ex_t norm(input ex_t e);
        ex_t r;
        r = e;
        if (r.illegal) begin
            r.a_sel = '0;
            r.b_sel = '0;
            r.imm   = '0;
            r.rs1   = '0;
            r.rs2   = '0;
        end
        return r;
    endfunction

    // ALU op numbered by one-hot bit: ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9
    function automatic ex_t model(input logic v, input logic [31:0] ins, input logic [31:0] p);
        ex_t         e;
        int          base[8];
        int          idx;
        bit          ill;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] b_imm;
        logic [31:0] u_imm;
        logic [31:0] j_imm;
        base  = '{0, 2, 3, 4, 5, 6, 8, 9};
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        i_imm = 32'($signed(ins) >>> 20);
        s_imm = 32'(($signed(ins) >>> 25) * 32) + 32'(ins[11:7]);
        b_imm = 32'(($signed(ins) >>> 31) * 4096) + 32'(ins[7]) * 2048
              + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
        u_imm = ins & 32'hFFFF_F000;
        j_imm = 32'(($signed(ins) >>> 31) * 1048576) + 32'(ins[19:12]) * 4096
              + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
        e   = bubble();
        idx = 0;
        ill = 1'b0;
        if (!v) return e;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        case (opc)
            7'h33: begin
                if ((f3 == 0 || f3 == 5) ? (f7 == 0 || f7 == 7'h20) : (f7 == 0)) begin
                    idx = (f7 == 7'h20) ? ((f3 == 0) ? 1 : 7) : base[f3];
                    e.reg_write = 1'b1;
                end else ill = 1'b1;
            end
            7'h13: begin
                if ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20)) ill = 1'b1;
                else begin
                    idx = (f3 == 5 && f7 == 7'h20) ? 7 : base[f3];
                    e.b_sel = 2'd1;
                    e.reg_write = 1'b1;
                    e.imm = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : i_imm;
                end
            end
            7'h63: begin
                if (f3 == 2 || f3 == 3) ill = 1'b1;
                else begin
                    idx = 1; e.bropcode = f3; e.is_branch = 1'b1; e.imm = b_imm;
                end
            end
            7'h03: begin e.b_sel = 2'd1; e.imm = i_imm; e.mem_read = 1'b1; e.reg_write = 1'b1; end
            7'h23: begin e.b_sel = 2'd1; e.imm = s_imm; e.mem_write = 1'b1; end
            7'h37: begin e.a_sel = 2'd2; e.b_sel = 2'd1; e.imm = u_imm; e.reg_write = 1'b1; end
            7'h17: begin e.a_sel = 2'd1; e.b_sel = 2'd1; e.imm = u_imm; e.reg_write = 1'b1; end
            7'h6f: begin
                e.a_sel = 2'd1; e.b_sel = 2'd2; e.imm = j_imm; e.is_jump = 1'b1; e.reg_write = 1'b1;
            end
            7'h67: begin
                if (f3 != 0) ill = 1'b1;
                else begin
                    e.a_sel = 2'd1; e.b_sel = 2'd2; e.imm = i_imm;
                    e.is_jump = 1'b1; e.reg_write = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            e = bubble();
            e.out_valid = 1'b1;
            e.illegal = 1'b1;
            e.pc_q = p;
            return e;
        end
        e.out_valid = 1'b1;
        e.pc_q = p;
        e.alu_ctrl = 10'(1) << idx;
        e.rd = e.reg_write ? ins[11:7] : 5'd0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs[9];
        logic [31:0] w;
        int          k;
        opcs = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67};
        w = $urandom;
        k = $urandom_range(0, 9);
        if (k < 9) w[6:0] = opcs[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        if (w[6:0] == 7'h67 && $urandom_range(0, 1) == 1) w[14:12] = 3'b000;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; stall = 1'b0; flush = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (observe() !== bubble() || ill_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h cnt %0d, exp %h cnt 0", observe(), ill_cnt, bubble());
        end
        rst_n = 1'b1;
        tick();
        exp_cnt = 0;
    endtask

    task automatic test_add_sub();
        in_valid = 1'b1; instr = 32'h002081B3; pc = 32'h0000_1000;
        tick();
        n_cmp++;
        if (alu_ctrl !== 10'h001 || rs1 !== 5'd1 || rs2 !== 5'd2 || rd !== 5'd3 ||
            reg_write !== 1'b1 || b_sel !== 2'd0 || out_valid !== 1'b1 || pc_q !== 32'h1000) begin
            n_fail++;
            $display("FAIL add: got alu %h rs1 %0d rs2 %0d rd %0d rw %b bsel %0d, exp 001 1 2 3 1 0",
                     alu_ctrl, rs1, rs2, rd, reg_write, b_sel);
        end
        instr = 32'h402081B3;
        tick();
        n_cmp++;
        if (alu_ctrl !== 10'h002 || rd !== 5'd3) begin
            n_fail++;
            $display("FAIL sub: got alu %h rd %0d, exp 002 3", alu_ctrl, rd);
        end
    endtask

    task automatic test_srai_illegal();
        instr = 32'h40335293;
        tick();
        n_cmp++;
        if (alu_ctrl !== 10'h080 || b_sel !== 2'd1 || imm !== 32'h3 || rd !== 5'd5 ||
            rs1 !== 5'd6 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL srai: got alu %h bsel %0d imm %h rd %0d, exp 080 1 3 5",
                     alu_ctrl, b_sel, imm, rd);
        end
        instr = 32'h42335293;
        tick();
        exp_cnt++;
        n_cmp++;
        if (illegal !== 1'b1 || alu_ctrl !== 10'h000 || out_valid !== 1'b1 || bropcode !== 3'b010 ||
            reg_write !== 1'b0 || rd !== 5'd0 || int'(ill_cnt) != exp_cnt) begin
            n_fail++;
            $display("FAIL srai_bad_funct7: got ill %b alu %h cnt %0d, exp 1 000 %0d",
                     illegal, alu_ctrl, ill_cnt, exp_cnt);
        end
    endtask

    task automatic test_branch();
        instr = 32'h00208463;
        tick();
        n_cmp++;
        if (alu_ctrl !== 10'h002 || bropcode !== 3'b000 || is_branch !== 1'b1 ||
            imm !== 32'h8 || reg_write !== 1'b0 || rd !== 5'd0 || b_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL beq: got alu %h brop %b br %b imm %h rw %b rd %0d, exp 002 000 1 8 0 0",
                     alu_ctrl, bropcode, is_branch, imm, reg_write, rd);
        end
    endtask

    task automatic test_stall_flush();
        instr = 32'h002081B3;
        tick();
        instr = 32'h402081B3; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (alu_ctrl !== 10'h001 || rd !== 5'd3 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got alu %h rd %0d, exp 001 3", i, alu_ctrl, rd);
            end
        end
        flush = 1'b1;
        tick();
        n_cmp++;
        if (observe() !== bubble() || int'(ill_cnt) != exp_cnt) begin
            n_fail++;
            $display("FAIL flush_over_stall: got %h, exp %h", observe(), bubble());
        end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_async_reset();
        instr = 32'hFFFF_FFFF;
        tick();
        instr = 32'h002081B3; stall = 1'b1;
        tick();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (observe() !== bubble() || ill_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset_mid_stall: got %h cnt %0d, exp %h cnt 0",
                     observe(), ill_cnt, bubble());
        end
        exp_cnt = 0;
        #2 rst_n = 1'b1; stall = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        in_valid = 1'b1; instr = 32'hFFFF_FFFF;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (exp_cnt < CntMax) exp_cnt++;
            if (i == 254) begin
                n_cmp++;
                if (int'(ill_cnt) != CntMax) begin
                    n_fail++;
                    $display("FAIL ill_cnt_reach_max: got %0d, exp %0d", ill_cnt, CntMax);
                end
            end
        end
        n_cmp++;
        if (int'(ill_cnt) != exp_cnt || illegal !== 1'b1 || alu_ctrl !== 10'h000) begin
            n_fail++;
            $display("FAIL ill_cnt_saturate: got %0d ill %b, exp %0d 1", ill_cnt, illegal, exp_cnt);
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (int'(ill_cnt) != exp_cnt || out_valid !== 1'b0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_no_count: got cnt %0d valid %b, exp %0d 0",
                     ill_cnt, out_valid, exp_cnt);
        end
    endtask

    task automatic test_random();
        ex_t exp_st;
        ex_t nxt;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        exp_st = bubble();
        exp_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 4) != 0);
            stall    = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            instr    = rand_instr();
            pc       = $urandom & 32'hFFFF_FFFC;
            tick();
            if (flush) exp_st = bubble();
            else if (!stall) begin
                nxt = model(in_valid, instr, pc);
                if (nxt.illegal && exp_cnt < CntMax) exp_cnt++;
                exp_st = nxt;
            end
            n_cmp++;
            if (norm(observe()) !== norm(exp_st) || int'(ill_cnt) != exp_cnt) begin
                n_fail++;
                $display("FAIL random[%0d] instr %h: got %h cnt %0d, exp %h cnt %0d",
                         i, instr, observe(), ill_cnt, exp_st, exp_cnt);
            end
        end
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_srai_illegal();
        test_branch();
        test_stall_flush();
        test_async_reset();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
